// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Sweeps the four {a,b} input combinations into an external two-input gate.
// After each vector it waits SETTLE_CYCLES cycles and samples the gate output.
// Each sample is compared with the truth table of the selected gate.
// At the end of the sweep it reports a pass flag, a per-vector fail mask and
// a fail count.
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN. When it is defined, the sweep
// ends at the first mismatching vector.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [2:0] i_gate_sel,
  output logic       o_dut_a,
  output logic       o_dut_b,
  input  logic       i_dut_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_mask,
  output logic [2:0] o_fail_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The counter counts down to zero, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 32'd1);
  localparam logic [2:0] SEL_RESERVED = 3'd7;

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  // Returns the expected gate output for the selected gate and the given inputs.
  function automatic logic f_expected(input logic [2:0] sel, input logic a, input logic b);
    logic e;
    case (sel)
      3'd0:    e = ~a;
      3'd1:    e = a & b;
      3'd2:    e = a | b;
      3'd3:    e = ~(a & b);
      3'd4:    e = ~(a | b);
      3'd5:    e = a ^ b;
      3'd6:    e = ~(a ^ b);
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  // Returns the number of set bits in a 4-bit mask (0..4).
  function automatic logic [2:0] f_popcount4(input logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

  state_t     r_state;
  logic [2:0] r_sel;
  logic [1:0] r_vec;
  logic [7:0] r_cnt;
  logic       r_dut_a;
  logic       r_dut_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_mask;
  logic [2:0] r_fail_count;

  state_t     w_state_nxt;
  logic [2:0] w_sel_nxt;
  logic [1:0] w_vec_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_dut_a_nxt;
  logic       w_dut_b_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic [3:0] w_fail_mask_nxt;
  logic [2:0] w_fail_count_nxt;

  logic       w_expected;
  logic       w_mismatch;
  logic [1:0] w_vec_inc;
  logic [3:0] w_vec_onehot;
  logic [3:0] w_mask_upd;

  // The expected value is taken from the driven inputs, which always equal r_vec.
  assign w_expected   = f_expected(r_sel, r_dut_a, r_dut_b);
  // The case-inequality operator makes an X/Z output count as a mismatch.
  assign w_mismatch   = (i_dut_c !== w_expected);
  assign w_vec_inc    = r_vec + 2'd1;
  assign w_vec_onehot = 4'b0001 << r_vec;
  assign w_mask_upd   = r_fail_mask | (w_mismatch ? w_vec_onehot : 4'b0000);

  // Next-state and next-register logic for the sweep sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_vec_nxt        = r_vec;
    w_cnt_nxt        = r_cnt;
    w_dut_a_nxt      = r_dut_a;
    w_dut_b_nxt      = r_dut_b;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_pass_nxt       = r_pass;
    w_fail_mask_nxt  = r_fail_mask;
    w_fail_count_nxt = r_fail_count;

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (i_start) begin
          w_busy_nxt = 1'b1;
          w_pass_nxt = 1'b0;
          if (i_gate_sel == SEL_RESERVED) begin
            // Reserved selector: report every vector as failed and drive nothing.
            // DONE is entered with done still low, so done rises one cycle later.
            w_state_nxt      = ST_DONE;
            w_fail_mask_nxt  = 4'hF;
            w_fail_count_nxt = 3'd4;
          end else begin
            w_state_nxt      = ST_SETTLE;
            w_sel_nxt        = i_gate_sel;
            w_vec_nxt        = 2'd0;
            w_dut_a_nxt      = 1'b0;
            w_dut_b_nxt      = 1'b0;
            w_cnt_nxt        = SETTLE_LOAD;
            w_fail_mask_nxt  = 4'h0;
            w_fail_count_nxt = 3'd0;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      ST_SAMPLE: begin
        w_fail_mask_nxt = w_mask_upd;
        if (STOP_ON_FAIL && w_mismatch) begin
          // Early stop: hold the failing vector. DONE is entered with done
          // still low, so done rises one cycle later.
          w_state_nxt      = ST_DONE;
          w_pass_nxt       = 1'b0;
          w_fail_count_nxt = f_popcount4(w_mask_upd);
        end else if (r_vec == 2'd3) begin
          w_state_nxt      = ST_DONE;
          w_done_nxt       = 1'b1;
          w_pass_nxt       = (w_mask_upd == 4'h0);
          w_fail_count_nxt = f_popcount4(w_mask_upd);
        end else begin
          w_state_nxt = ST_SETTLE;
          w_vec_nxt   = w_vec_inc;
          w_dut_a_nxt = w_vec_inc[1];
          w_dut_b_nxt = w_vec_inc[0];
          w_cnt_nxt   = SETTLE_LOAD;
        end
      end

      ST_DONE: begin
        if (r_done) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          // Entered with done low: raise done now and stay one more cycle.
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; reset aborts any sweep without a done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel        <= 3'd0;
      r_vec        <= 2'd0;
      r_cnt        <= 8'd0;
      r_dut_a      <= 1'b0;
      r_dut_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_mask  <= 4'h0;
      r_fail_count <= 3'd0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_vec        <= w_vec_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dut_a      <= w_dut_a_nxt;
      r_dut_b      <= w_dut_b_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_fail_mask  <= w_fail_mask_nxt;
      r_fail_count <= w_fail_count_nxt;
    end
  end

  assign o_dut_a      = r_dut_a;
  assign o_dut_b      = r_dut_b;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_fail_mask  = r_fail_mask;
  assign o_fail_count = r_fail_count;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Testbench for gate_truth_checker.
// The external gate is modelled as a 4-entry truth table indexed by {a,b}.
// A scoreboard queue holds the result expected for each sweep. A monitor
// pops one entry on every done pulse and compares it with the outputs.
module tb_gate_truth_checker;

  localparam int S      = 2;
  localparam int PERIOD = 10;
  localparam int HALF   = PERIOD / 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  logic       dut_a;
  logic       dut_b;
  logic       dut_c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] fail_count;

  // Truth table of the gate wired to the checker, bit index = {a,b}.
  logic [3:0] gate_tt;

  typedef struct {
    logic [3:0]  mask;
    logic [2:0]  cnt;
    logic        pass;
    logic        a;
    logic        b;
    longint      t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  gate_truth_checker #(.SETTLE_CYCLES(S)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_gate_sel   (gate_sel),
    .o_dut_a      (dut_a),
    .o_dut_b      (dut_b),
    .i_dut_c      (dut_c),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass       (pass),
    .o_fail_mask  (fail_mask),
    .o_fail_count (fail_count)
  );

  assign dut_c = gate_tt[{dut_a, dut_b}];

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  // Compare one value and report a mismatch.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truth table of gate 'sel', worked out from integer arithmetic on a and b.
  function automatic logic [3:0] tt_of(input int sel);
    logic [3:0] t;
    int a;
    int b;
    int v;
    t = 4'h0;
    for (int i = 0; i < 4; i++) begin
      a = i / 2;
      b = i % 2;
      case (sel)
        0:       v = 1 - a;
        1:       v = a * b;
        2:       v = (a + b > 0) ? 1 : 0;
        3:       v = 1 - a * b;
        4:       v = (a + b == 0) ? 1 : 0;
        5:       v = (a + b) % 2;
        6:       v = 1 - (a + b) % 2;
        default: v = 0;
      endcase
      t[i] = (v != 0);
    end
    return t;
  endfunction

  // Monitor: on every done pulse, pop the expected result and compare.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_time",  32'($time),     32'(mon_e.t));
        chk("fail_mask",  32'(fail_mask), 32'(mon_e.mask));
        chk("fail_count", 32'(fail_count), 32'(mon_e.cnt));
        chk("pass",       32'(pass),      32'(mon_e.pass));
        chk("end_dut_a",  32'(dut_a),     32'(mon_e.a));
        chk("end_dut_b",  32'(dut_b),     32'(mon_e.b));
      end
    end
  end

  // Run one sweep: set the gate table, pulse start, push the expected result
  // and check the driven vector sequence and busy in every cycle.
  task automatic sweep(input logic [2:0] sel, input logic [3:0] obs,
                       input bit toggle, input bit do_reset);
    exp_t       e;
    logic [3:0] diff;
    logic [1:0] lv;
    logic       pa;
    logic       pb;
    int         last;
    int         lat;
    int         ev;
    bit         aborted;
    @(negedge clk);
    gate_tt = obs;
    pa      = dut_a;
    pb      = dut_b;
    aborted = 1'b0;
    diff    = tt_of(int'(sel)) ^ obs;
    if (sel == 3'd7) begin
      e.mask = 4'hF;
      last   = -1;
      lat    = 1;
      e.a    = pa;
      e.b    = pb;
    end else begin
      e.mask = diff;
      last   = 3;
      lat    = 4 * (S + 1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      for (int i = 3; i >= 0; i--) begin
        if (diff[i]) begin
          last   = i;
          e.mask = 4'b0001 << i;
          lat    = (i + 1) * (S + 1) + 1;
        end
      end
`endif
      lv  = 2'(last);
      e.a = lv[1];
      e.b = lv[0];
    end
    e.cnt  = 3'($countones(e.mask));
    e.pass = (e.mask == 4'h0);
    e.t    = longint'($time) + longint'((lat + 1) * PERIOD);
    start    = 1'b1;
    gate_sel = sel;
    exp_q.push_back(e);
    for (int k = 0; k <= lat + 1 && !aborted; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (sel == 3'd7) begin
        chk("hold_dut_a", 32'(dut_a), 32'(pa));
        chk("hold_dut_b", 32'(dut_b), 32'(pb));
      end else begin
        ev = (k / (S + 1) < last) ? k / (S + 1) : last;
        chk("seq_dut_a", 32'(dut_a), 32'(ev / 2));
        chk("seq_dut_b", 32'(dut_b), 32'(ev % 2));
      end
      chk("busy", 32'(busy), (k <= lat) ? 32'd1 : 32'd0);
      if (k == lat + 1) begin
        chk("held_mask", 32'(fail_mask), 32'(e.mask));
        chk("held_pass", 32'(pass), 32'(e.pass));
      end
      if (toggle && k == 5 && lat >= 5) begin
        start    = 1'b1;
        gate_sel = 3'($urandom_range(0, 7));
      end
      if (k == 6) start = 1'b0;
      if (do_reset && k == 6) begin
        #(HALF + 1);
        rst = 1'b1;
        #1;
        chk("rst_dut_a", 32'(dut_a), 32'd0);
        chk("rst_dut_b", 32'(dut_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_mask", 32'(fail_mask), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        aborted = 1'b1;
      end
    end
    start = 1'b0;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    gate_sel = 3'd0;
    gate_tt  = 4'h0;
    @(negedge clk);
    chk("reset_dut_a", 32'(dut_a), 32'd0);
    chk("reset_dut_b", 32'(dut_b), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_fail_mask", 32'(fail_mask), 32'd0);
    chk("reset_fail_count", 32'(fail_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // AND checked against a real AND gate.
    sweep(3'd1, tt_of(1), 1'b0, 1'b0);
    // XOR checked against an OR gate: vector 3 differs.
    sweep(3'd5, tt_of(2), 1'b0, 1'b0);
    // Every legal selector against its matching gate.
    for (int s = 0; s < 7; s++) sweep(3'(s), tt_of(s), 1'b0, 1'b0);
    // NOT with the output tied low: vectors 0 and 1 fail.
    sweep(3'd0, 4'h0, 1'b0, 1'b0);
    // Reserved selector: immediate fail, no vectors driven.
    sweep(3'd7, tt_of(1), 1'b0, 1'b0);
    // Start and gate_sel toggled mid-sweep: both ignored.
    sweep(3'd1, tt_of(1), 1'b1, 1'b0);
    // Reset in the middle of a sweep, then a normal sweep.
    sweep(3'd2, tt_of(2), 1'b0, 1'b1);
    sweep(3'd3, tt_of(3), 1'b0, 1'b0);
    // AND with the output tied high: vectors 0..2 fail.
    sweep(3'd1, 4'hF, 1'b0, 1'b0);

    // Random selectors, with either the matching gate or a random table.
    for (int n = 0; n < 30; n++) begin
      logic [2:0] rs;
      logic [3:0] rt;
      rs = 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 1) == 1) ? tt_of(int'(rs)) : 4'($urandom_range(0, 15));
      sweep(rs, rt, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation exceeded %0d cycles", 20000);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Self-checking sweeper for the two-input gate library (not, and, or, nand, nor, xor, xnor).
- Drives all four {a,b} combinations into an external gate instance and samples its output after a settle delay.
- Compares each sample against the truth table of the selected gate and reports pass/fail per vector.
- Response/checking end of the gate stimulus interface; used in on-chip self-test and by benches.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling dut_c; legal range 1..255 (8-bit counter).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin sweep; accepted only in IDLE
- gate_sel  input  3  0 NOT, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved
- dut_a  output  1  gate input a (registered)
- dut_b  output  1  gate input b (registered)
- dut_c  input  1  gate output under test
- busy  output  1  high while a sweep is in progress (SETTLE, SAMPLE, DONE)
- done  output  1  one-cycle pulse at end of sweep
- pass  output  1  1 = all vectors matched; held until next accepted start
- fail_mask  output  4  bit i set = vector i mismatched; held
- fail_count  output  3  popcount of fail_mask (0..4); held

Behaviour:
- Reset (async, any state): FSM = IDLE; dut_a, dut_b, busy, done, pass = 0; fail_mask = 0; fail_count = 0; vector index = 0; settle counter = 0.
- Vector index vec[1:0]: dut_a = vec[1], dut_b = vec[0]; order 0,1,2,3.
- Expected value: NOT = ~a (b driven but ignored); AND a&b; OR a|b; NAND ~(a&b); NOR ~(a|b); XOR a^b; XNOR ~(a^b).
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1, gate_sel != 7, on edge E0:
  - latch gate_sel
  - clear fail_mask, fail_count and pass
  - set vec = 0 and drive dut_a = dut_b = 0 from E0
  - load settle counter and go to SETTLE
- IDLE, start=1, gate_sel == 7: go to DONE; fail_mask = 4'hF, fail_count = 4, pass = 0. done pulses on the cycle after E0; no vectors are driven.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (one cycle): compare dut_c at the closing edge.
  - On mismatch, set fail_mask[vec].
  - If vec == 3, go to DONE.
  - Otherwise increment vec, drive the new dut_a/dut_b on that same edge, reload the counter and go to SETTLE.
- Per-vector time = SETTLE_CYCLES + 1 cycles.
- DONE (one cycle): done = 1; pass = (fail_mask == 0); fail_count valid; next state IDLE.
  - done high in the cycle beginning at edge E0 + 4*(SETTLE_CYCLES+1).
  - Default SETTLE_CYCLES = 2: done at E0 + 12.
- dut_a/dut_b hold their last vector after the sweep until the next start or reset.
- start while not in IDLE: ignored, no queuing. start during the DONE cycle is also ignored.
- gate_sel changes mid-sweep: ignored; the latched copy is used.
- dut_c X/Z: treated as mismatch.
  - The comparator must flag any non-0/1 value as fail.
  - Implemented as !== in simulation; in synthesis, X/Z cannot occur.
- Reset mid-sweep: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: on the first mismatch in SAMPLE, go directly to DONE (done next cycle). Only that vector's bit is set in fail_mask; fail_count = 1; dut_a/dut_b hold the failing vector.
- Undefined: full four-vector sweep always; all mismatches are recorded.

Test Plan:
- SETTLE_CYCLES=2, gate_sel=1, dut_c from a real and_gate, start at E0 -> dut_a/dut_b step 00,01,10,11 every 3 cycles; done at E0+12 only; pass=1, fail_mask=0000, fail_count=0.
- gate_sel=5, dut_c wired to or_gate -> fail_mask=1000, fail_count=1, pass=0; repeat for all of sel 0..6 with the matching gate -> pass=1 each.
- gate_sel=0, dut_c tied 0 -> fail_mask=0011, fail_count=2, pass=0; gate_sel=7 -> done at E0+1, fail_mask=1111, fail_count=4, no change on dut_a/dut_b.
- Pulse start again and toggle gate_sel at E0+5 during a sweep -> no restart; result uses the original sel; done once at E0+12.
- Assert rst at E0+7 -> dut_a, dut_b, busy, done, pass, fail_mask, fail_count all 0 asynchronously; no done pulse; a new start after release sweeps normally.
- With GATE_CHK_STOP_ON_FAIL_EN, gate_sel=1, dut_c tied 1 -> fail at vec 0; done at E0+4; fail_mask=0001, fail_count=1, dut_a=dut_b=0.
